// File: rtl/vga.svh
// Screen geometry shared by the VGA-domain blocks.
//   H_DISPLAY / V_DISPLAY : visible pixels per line / visible lines
//   H_SIZE / V_SIZE       : bit widths of x / y pixel coordinates
`ifndef VGA_SVH
`define VGA_SVH
`define H_DISPLAY 640
`define V_DISPLAY 480
`define H_SIZE 10
`define V_SIZE 10
`endif

// File: rtl/dla_particle_check.sv
// dla_particle_check: decides whether a diffusion-limited-aggregation walker has stuck.
// A particle sticks when it sits on the screen edge, or when any of its 8 neighbours is
// occupied in VRAM. Neighbours are read one at a time over an Avalon-MM master port and
// the scan stops at the first occupied one.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   check_x, check_y          particle coordinate, sampled with check_start in idle
//   check_start               single-cycle request strobe
//   check_done                single-cycle completion pulse
//   hit_boundary              particle is on the screen edge (held until next request)
//   hit_neighbor              an occupied neighbour was found (held until next request)
//   vram_avn_*                Avalon-MM read master into VRAM, one word per pixel
`include "vga.svh"

module dla_particle_check #(
    parameter int unsigned AVN_AW = 19,
    parameter int unsigned AVN_DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`H_SIZE-1:0]   check_x,
    input  logic [`V_SIZE-1:0]   check_y,
    input  logic                 check_start,
    output logic                 check_done,
    output logic                 hit_boundary,
    output logic                 hit_neighbor,
    output logic [AVN_AW-1:0]    vram_avn_address,
    output logic                 vram_avn_read,
    input  logic [AVN_DW-1:0]    vram_avn_readdata,
    input  logic                 vram_avn_waitrequest,
    input  logic                 vram_avn_readdatavalid
);

    typedef enum logic [4:0] {
        StIdle  = 5'b00001,
        StBound = 5'b00010,
        StRead  = 5'b00100,
        StWait  = 5'b01000,
        StDone  = 5'b10000
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               hit_boundary_q, hit_boundary_d;
    logic               hit_neighbor_q, hit_neighbor_d;
    logic [`H_SIZE-1:0] cur_x;
    logic [`V_SIZE-1:0] cur_y;

    logic               is_boundary;
    logic [1:0]         dx, dy;    // neighbour offset plus one (0 => -1, 2 => +1)
    logic [AVN_AW-1:0]  nx, ny;

    assign is_boundary = (cur_x == '0) || (cur_x == `H_SIZE'(`H_DISPLAY - 1)) ||
                         (cur_y == '0) || (cur_y == `V_SIZE'(`V_DISPLAY - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            hit_boundary_q <= 1'b0;
            hit_neighbor_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            hit_boundary_q <= hit_boundary_d;
            hit_neighbor_q <= hit_neighbor_d;
        end
    end

    // Coordinates are only meaningful once a request has been accepted, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == StIdle && check_start) begin
            cur_x <= check_x;
            cur_y <= check_y;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        hit_boundary_d = hit_boundary_q;
        hit_neighbor_d = hit_neighbor_q;
        unique case (state_q)
            StIdle: begin
                if (check_start) begin
                    hit_boundary_d = 1'b0;
                    hit_neighbor_d = 1'b0;
                    state_d        = StBound;
                end
            end
            StBound: begin
                if (is_boundary) begin
                    hit_boundary_d = 1'b1;
                    state_d        = StDone;
                end else begin
                    idx_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (!vram_avn_waitrequest) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (vram_avn_readdatavalid) begin
                    if (vram_avn_readdata != '0) begin
                        hit_neighbor_d = 1'b1;
                        state_d        = StDone;
                    end else if (idx_q == 3'd7) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Neighbour scan order: row above left-to-right, left/right, row below left-to-right.
    always_comb begin
        dx = 2'd1;
        dy = 2'd1;
        unique case (idx_q)
            3'd0: begin dx = 2'd0; dy = 2'd0; end
            3'd1: begin dx = 2'd1; dy = 2'd0; end
            3'd2: begin dx = 2'd2; dy = 2'd0; end
            3'd3: begin dx = 2'd0; dy = 2'd1; end
            3'd4: begin dx = 2'd2; dy = 2'd1; end
            3'd5: begin dx = 2'd0; dy = 2'd2; end
            3'd6: begin dx = 2'd1; dy = 2'd2; end
            3'd7: begin dx = 2'd2; dy = 2'd2; end
            default: begin dx = 2'd1; dy = 2'd1; end
        endcase
    end

    // Non-boundary particles only reach the read states, so nx/ny never wrap.
    assign nx = AVN_AW'(cur_x) + AVN_AW'(dx) - AVN_AW'(1);
    assign ny = AVN_AW'(cur_y) + AVN_AW'(dy) - AVN_AW'(1);

    // Outputs
    always_comb begin
        vram_avn_read    = (state_q == StRead);
        check_done       = (state_q == StDone);
        hit_boundary     = hit_boundary_q;
        hit_neighbor     = hit_neighbor_q;
        vram_avn_address = nx + ny * AVN_AW'(`H_DISPLAY);
    end

endmodule

// File: tb/tb_dla_particle_check.sv
`include "vga.svh"

module tb_dla_particle_check;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int HD = `H_DISPLAY;
    localparam int VD = `V_DISPLAY;

    logic                clk;
    logic                rst;
    logic [`H_SIZE-1:0]  check_x;
    logic [`V_SIZE-1:0]  check_y;
    logic                check_start;
    logic                check_done;
    logic                hit_boundary;
    logic                hit_neighbor;
    logic [AW-1:0]       vram_avn_address;
    logic                vram_avn_read;
    logic [DW-1:0]       vram_avn_readdata;
    logic                vram_avn_waitrequest;
    logic                vram_avn_readdatavalid;

    dla_particle_check #(.AVN_AW(AW), .AVN_DW(DW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .check_x                (check_x),
        .check_y                (check_y),
        .check_start            (check_start),
        .check_done             (check_done),
        .hit_boundary           (hit_boundary),
        .hit_neighbor           (hit_neighbor),
        .vram_avn_address       (vram_avn_address),
        .vram_avn_read          (vram_avn_read),
        .vram_avn_readdata      (vram_avn_readdata),
        .vram_avn_waitrequest   (vram_avn_waitrequest),
        .vram_avn_readdatavalid (vram_avn_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // VRAM slave model: sparse memory, configurable stalls and response latency.
    logic [15:0] mem [int];
    int  stall_first = 0;
    int  stall_rest  = 0;
    int  resp_lat    = 1;
    int  acc_q [$];
    bit  in_read     = 0;
    int  stall_cnt   = 0;
    bit  pend        = 0;
    int  pend_cnt    = 0;
    int  pend_addr   = 0;
    int  stall_addr_exp = 0;

    initial begin
        vram_avn_waitrequest   = 1'b0;
        vram_avn_readdatavalid = 1'b0;
        vram_avn_readdata      = '0;
    end

    always @(negedge clk) begin
        vram_avn_readdatavalid = 1'b0;
        vram_avn_readdata      = '0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend = 0;
                vram_avn_readdatavalid = 1'b1;
                vram_avn_readdata = mem.exists(pend_addr) ? mem[pend_addr] : 16'h0;
            end
        end
        if (vram_avn_read === 1'b1) begin
            if (!in_read) begin
                in_read   = 1;
                stall_cnt = (acc_q.size() == 0) ? stall_first : stall_rest;
            end
            if (stall_cnt > 0) begin
                vram_avn_waitrequest = 1'b1;
                stall_cnt--;
                if (acc_q.size() == 0)
                    chk("stall_addr", 32'(vram_avn_address), 32'(stall_addr_exp));
            end else begin
                vram_avn_waitrequest = 1'b0;
                in_read   = 0;
                acc_q.push_back(int'(vram_avn_address));
                pend      = 1;
                pend_cnt  = resp_lat;
                pend_addr = int'(vram_avn_address);
            end
        end else begin
            vram_avn_waitrequest = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Reference: which neighbours get read, in scan order, and the outcome.
    task automatic model(input int x, input int y, output bit bnd, output bit hit,
                         output int addrs[$]);
        addrs.delete();
        hit = 0;
        bnd = (x == 0) || (x == HD - 1) || (y == 0) || (y == VD - 1);
        if (!bnd) begin
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    if (!hit && !(dx == 0 && dy == 0)) begin
                        int a;
                        a = (x + dx) + (y + dy) * HD;
                        addrs.push_back(a);
                        if (mem.exists(a) && mem[a] != 16'h0) hit = 1;
                    end
                end
            end
        end
    endtask

    task automatic run_check(input int x, input int y, input string tag);
        bit bnd, hit, done_seen, read_seen;
        int exp_addrs[$];
        int n, exp_lat, nr;
        model(x, y, bnd, hit, exp_addrs);
        nr = exp_addrs.size();
        exp_lat = bnd ? 2 : 2 + nr * (1 + resp_lat) + stall_first + stall_rest * (nr - 1);
        acc_q.delete();
        check_x = `H_SIZE'(x);
        check_y = `V_SIZE'(y);
        check_start = 1'b1;
        n = 0;
        done_seen = 0;
        read_seen = 0;
        while (!done_seen && n < 400) begin
            step();
            n++;
            check_start = 1'b0;
            if (vram_avn_read === 1'b1) read_seen = 1;
            if (n == 1) chk({tag, "_clr"}, {30'd0, hit_boundary, hit_neighbor}, 32'd0);
            if (check_done === 1'b1) done_seen = 1;
        end
        chk({tag, "_done"}, 32'(done_seen), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_hb"}, 32'(hit_boundary), 32'(bnd));
        chk({tag, "_hn"}, 32'(hit_neighbor), 32'(hit));
        chk({tag, "_excl"}, 32'(hit_boundary & hit_neighbor), 32'd0);
        if (bnd) chk({tag, "_noread"}, 32'(read_seen), 32'd0);
        chk({tag, "_nreads"}, 32'(acc_q.size()), 32'(nr));
        for (int i = 0; i < nr && i < acc_q.size(); i++)
            chk({tag, "_addr"}, 32'(acc_q[i]), 32'(exp_addrs[i]));
        step();
        chk({tag, "_pulse"}, 32'(check_done), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        check_x = '0;
        check_y = '0;
        check_start = 1'b0;
        repeat (3) step();
        chk("rst_done", 32'(check_done), 32'd0);
        chk("rst_hb", 32'(hit_boundary), 32'd0);
        chk("rst_hn", 32'(hit_neighbor), 32'd0);
        chk("rst_read", 32'(vram_avn_read), 32'd0);
        rst = 1'b0;
        step();

        // Left-edge particle: no reads, done two cycles after the request.
        run_check(0, 200, "bound_x0");

        // Interior particle, empty VRAM: all eight neighbours read.
        run_check(100, 50, "miss");

        // Only the right-hand neighbour occupied: scan stops after the fifth read.
        mem[32101] = 16'hFFFF;
        run_check(100, 50, "hit_idx4");
        mem.delete();

        // Slave stalls the first read for three cycles.
        stall_first = 3;
        stall_addr_exp = 31459;
        run_check(100, 50, "stall");
        stall_first = 0;

        // Request held through the done cycle must not start a new check.
        check_x = `H_SIZE'(0);
        check_y = `V_SIZE'(5);
        check_start = 1'b1;
        step();
        check_start = 1'b0;
        step();
        chk("dstart_done", 32'(check_done), 32'd1);
        check_x = `H_SIZE'(100);
        check_y = `V_SIZE'(50);
        check_start = 1'b1;
        step();
        check_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dstart_idle", {30'd0, check_done, vram_avn_read}, 32'd0);
        end
        chk("dstart_hold", 32'(hit_boundary), 32'd1);

        // Reset while waiting for read data; the late response lands in idle.
        mem[31459] = 16'hFFFF;
        resp_lat = 3;
        acc_q.delete();
        check_x = `H_SIZE'(100);
        check_y = `V_SIZE'(50);
        check_start = 1'b1;
        step();
        check_start = 1'b0;
        begin
            int n;
            n = 0;
            while (acc_q.size() == 0 && n < 20) begin
                step();
                n++;
            end
        end
        chk("abort_accept", 32'(acc_q.size()), 32'd1);
        step();
        chk("abort_inwait", 32'(vram_avn_read), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_read = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_quiet",
                {28'd0, check_done, hit_boundary, hit_neighbor, vram_avn_read}, 32'd0);
        end
        resp_lat = 1;
        mem.delete();
        run_check(0, 0, "post_abort");

        // Back-to-back: corner particle, then its inner diagonal neighbour.
        mem[637 + 477 * HD] = 16'h0001;
        run_check(639, 479, "corner");
        run_check(638, 478, "inner");
        mem.delete();

        // Randomised checks against the reference model.
        for (int t = 0; t < 40; t++) begin
            int x, y, r;
            r = int'($urandom_range(0, 7));
            x = (r == 0) ? 0 : (r == 1) ? HD - 1 : int'($urandom_range(1, HD - 2));
            r = int'($urandom_range(0, 7));
            y = (r == 0) ? 0 : (r == 1) ? VD - 1 : int'($urandom_range(1, VD - 2));
            mem.delete();
            if (x > 0 && x < HD - 1 && y > 0 && y < VD - 1) begin
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ($urandom_range(0, 4) == 0)
                            mem[(x + dx) + (y + dy) * HD] = 16'($urandom_range(1, 65535));
            end
            stall_first = int'($urandom_range(0, 2));
            stall_rest  = int'($urandom_range(0, 1));
            resp_lat    = int'($urandom_range(1, 3));
            stall_addr_exp = (x - 1) + (y - 1) * HD;
            run_check(x, y, "rand");
            repeat ($urandom_range(0, 2)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dla_particle_check.md
DLA_PARTICLE_CHECK -- requirements
Module: dla_particle_check

Interface
REQ-001 SHALL have parameter AVN_AW, default 19, VRAM Avalon address width.
REQ-002 SHALL have parameter AVN_DW, default 16, VRAM Avalon data width.
REQ-003 SHALL use `H_SIZE, `V_SIZE, `H_DISPLAY, `V_DISPLAY from vga.svh for coordinate widths and screen size.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 check_x  input  `H_SIZE  particle x to check.
REQ-007 check_y  input  `V_SIZE  particle y to check.
REQ-008 check_start  input  1  single-cycle request strobe.
REQ-009 check_done  output  1  single-cycle completion pulse.
REQ-010 hit_boundary  output  1  particle on screen edge; valid when check_done=1.
REQ-011 hit_neighbor  output  1  a neighbor pixel is occupied; valid when check_done=1.
REQ-012 vram_avn_address  output  AVN_AW  VRAM read word address.
REQ-013 vram_avn_read  output  1  Avalon read request.
REQ-014 vram_avn_readdata  input  AVN_DW  read data.
REQ-015 vram_avn_waitrequest  input  1  slave stall; read held while high.
REQ-016 vram_avn_readdatavalid  input  1  readdata valid strobe, latency >= 1 cycle after accepted read.

Function
REQ-017 SHALL be one-hot FSM with states IDLE, BOUND, READ, WAIT, DONE.
REQ-018 IDLE: on check_start=1, latch check_x/check_y into cur_x/cur_y, clear both hit flags, go BOUND; else stay; check_start outside IDLE SHALL be ignored.
REQ-019 BOUND: boundary = (cur_x==0) | (cur_x==`H_DISPLAY-1) | (cur_y==0) | (cur_y==`V_DISPLAY-1); if boundary set hit_boundary, go DONE, issue no reads; else reset neighbor index to 0, go READ.
REQ-020 Neighbor index order SHALL be 0:(x-1,y-1) 1:(x,y-1) 2:(x+1,y-1) 3:(x-1,y) 4:(x+1,y) 5:(x-1,y+1) 6:(x,y+1) 7:(x+1,y+1).
REQ-021 vram_avn_address SHALL equal zero-extended nx + ny*`H_DISPLAY for current neighbor (nx,ny), computed at AVN_AW width.
REQ-022 READ: vram_avn_read=1, address stable; go WAIT when vram_avn_waitrequest=0, else stay READ.
REQ-023 WAIT: vram_avn_read=0; on readdatavalid: readdata!=0 -> set hit_neighbor, go DONE (early exit); readdata==0 and index==7 -> go DONE with hit_neighbor=0; else increment index, go READ.
REQ-024 readdatavalid outside WAIT SHALL be ignored; at most one read outstanding.
REQ-025 DONE: check_done=1 for exactly one cycle, go IDLE; hit flags hold until next accepted check_start.
REQ-026 hit_boundary and hit_neighbor SHALL never both be 1.
REQ-027 Latency, zero-wait slave, readdatavalid 1 cycle after accept: start at T -> boundary check_done at T+2; first-neighbor hit at T+4; full miss at T+18.
REQ-028 check_start in the DONE cycle SHALL be ignored; accepted next cycle in IDLE only if reasserted.

Reset
REQ-029 On rst: state=IDLE, check_done=0, hit_boundary=0, hit_neighbor=0, vram_avn_read=0, index=0; cur_x/cur_y need no reset.
REQ-030 rst mid-operation (READ/WAIT) SHALL abort without check_done; a later readdatavalid for the aborted read SHALL be ignored in IDLE.

Verification
REQ-031 Start (0,200) -> check_done at T+2, hit_boundary=1, hit_neighbor=0, vram_avn_read never asserted.
REQ-032 Start (100,50), all VRAM zero, zero-wait -> 8 reads at addresses 31459,31460,31461,32099,32101,32739,32740,32741; check_done at T+18, both flags 0.
REQ-033 Start (100,50), readdata=0xFFFF at address 32101 (index 4) only -> reads stop after 5th; check_done with hit_neighbor=1.
REQ-034 waitrequest held high 3 cycles on first read -> vram_avn_read and address 31459 stable throughout; check_done delayed by 3 cycles.
REQ-035 rst asserted in WAIT, then readdatavalid=1 with 0xFFFF -> no check_done, flags 0, FSM in IDLE.
REQ-036 Start (639,479) and (638,478) back-to-back -> first hit_boundary=1; second performs reads, flags cleared on acceptance.
